river_move_gen: RTL

Autonomous player for the farmer/fox/chicken/seed river-crossing game. It drives the game checker's position inputs rather than sampling them. After a start pulse it emits a fixed legal 7-move solution as a sequence of 4-bit position vectors over a valid/ready handshake. After each accepted move it samples the checker's win/lose feedback and finishes in a DONE or FAIL state. It sits between a test/demo controller and the game checker, replacing the manual switch inputs.

---
 rtl/river_move_gen.sv | 156 +++++++++++++++
 1 files changed

// File: rtl/river_move_gen.sv
// Autonomous river-crossing player: presents a fixed 7-move solution over valid/ready and
// tracks checker feedback. Optional present-timeout when RIVER_TIMEOUT_EN is defined.
module river_move_gen #(
  parameter int unsigned GAP     = 2,
  parameter int unsigned TIMEOUT = 15
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic       alt,
  input  logic       move_ready,
  input  logic       win_i,
  input  logic       lose_i,
  output logic       move_valid,
  output logic [3:0] move,
  output logic [2:0] step,
  output logic       busy,
  output logic       done,
  output logic       fail
);

  typedef enum logic [2:0] {StIdle, StPresent, StCheck, StWait, StDone, StFail} state_e;

  localparam logic [3:0] GapW = 4'(GAP);

  state_e     state_q;
  logic       alt_q;
  logic [3:0] gap_q;
  logic       move_valid_q, busy_q, done_q, fail_q;
  logic [3:0] move_q;
  logic [2:0] step_q;
  logic [2:0] step_nxt;
  logic [3:0] move_nxt;

`ifdef RIVER_TIMEOUT_EN
  localparam logic [7:0] TimeoutW = 8'(TIMEOUT);
  logic [7:0] wait_q;
`else
  logic unused_timeout;
  assign unused_timeout = ^TIMEOUT;
`endif

  // Position vector {farmer, fox, chicken, seed} for a given step of either solution.
  function automatic logic [3:0] move_vec(input logic a, input logic [2:0] s);
    case (s)
      3'd1:    move_vec = 4'b1010;
      3'd2:    move_vec = 4'b0010;
      3'd3:    move_vec = a ? 4'b1011 : 4'b1110;
      3'd4:    move_vec = a ? 4'b0001 : 4'b0100;
      3'd5:    move_vec = 4'b1101;
      3'd6:    move_vec = 4'b0101;
      3'd7:    move_vec = 4'b1111;
      default: move_vec = 4'b0000;
    endcase
  endfunction

  always_comb begin
    step_nxt = step_q + 3'd1;
    move_nxt = move_vec(alt_q, step_nxt);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= StIdle;
      alt_q        <= 1'b0;
      gap_q        <= 4'd0;
      move_valid_q <= 1'b0;
      move_q       <= 4'd0;
      step_q       <= 3'd0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      fail_q       <= 1'b0;
`ifdef RIVER_TIMEOUT_EN
      wait_q       <= 8'd0;
`endif
    end else begin
      unique case (state_q)
        StIdle, StDone, StFail: begin
          if (start) begin
            state_q      <= StPresent;
            alt_q        <= alt;
            step_q       <= 3'd1;
            move_q       <= move_vec(alt, 3'd1);
            move_valid_q <= 1'b1;
            busy_q       <= 1'b1;
            done_q       <= 1'b0;
            fail_q       <= 1'b0;
`ifdef RIVER_TIMEOUT_EN
            wait_q       <= 8'd0;
`endif
          end
        end
        StPresent: begin
          if (move_ready) begin
            state_q      <= StCheck;
            move_valid_q <= 1'b0;
`ifdef RIVER_TIMEOUT_EN
          end else if (wait_q == TimeoutW - 8'd1) begin
            // Counter reaches TIMEOUT on this edge with no acceptance.
            state_q      <= StFail;
            move_valid_q <= 1'b0;
            busy_q       <= 1'b0;
            fail_q       <= 1'b1;
          end else begin
            wait_q <= wait_q + 8'd1;
`endif
          end
        end
        StCheck: begin
          if (lose_i || (step_q == 3'd7 && !win_i)) begin
            state_q <= StFail;
            busy_q  <= 1'b0;
            fail_q  <= 1'b1;
          end else if (step_q == 3'd7) begin
            state_q <= StDone;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
          end else if (GapW == 4'd0) begin
            state_q      <= StPresent;
            step_q       <= step_nxt;
            move_q       <= move_nxt;
            move_valid_q <= 1'b1;
`ifdef RIVER_TIMEOUT_EN
            wait_q       <= 8'd0;
`endif
          end else begin
            state_q <= StWait;
            gap_q   <= GapW;
          end
        end
        StWait: begin
          if (gap_q == 4'd1) begin
            state_q      <= StPresent;
            step_q       <= step_nxt;
            move_q       <= move_nxt;
            move_valid_q <= 1'b1;
`ifdef RIVER_TIMEOUT_EN
            wait_q       <= 8'd0;
`endif
          end else begin
            gap_q <= gap_q - 4'd1;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign move_valid = move_valid_q;
  assign move       = move_q;
  assign step       = step_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign fail       = fail_q;

endmodule
